data_mem_responder: RTL and testbench

- Word-addressed data-memory slave that answers the processor's load/store request interface (valid/ack handshake).
- Inserts a fixed, parameterised number of wait states so the processor's stall logic is exercised under realistic memory latency.
- Sits beside the processor core in the top-level and system testbenches as the responding end of the data bus.

---
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory slave with a fixed number of wait states per request.
// Optional DMEM_BOUNDS_CHECK_EN adds MemErr and rejects addresses >= DEPTH instead of wrapping.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemReq,
    input  logic              MemWe,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemWData,
    output logic              MemAck,
    output logic [DATA_W-1:0] MemRData,
    output logic              Busy
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              MemErr
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              enter_ack;
    logic              wr_en;
    logic [31:0]       addr_ext;
    logic [IDX_W-1:0]  idx;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (MemReq) state_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
            WAIT: if (cnt_reg == CNT_W'(1)) state_next = ACK;
            ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus is used in IDLE and the latched copy everywhere else.
    assign cur_we    = (state_reg == IDLE) ? MemWe    : we_reg;
    assign cur_addr  = (state_reg == IDLE) ? MemAddr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? MemWData : wdata_reg;
    assign enter_ack = (state_next == ACK);
    assign addr_ext  = 32'(cur_addr);
    assign idx       = IDX_W'(addr_ext % 32'(DEPTH));

`ifdef DMEM_BOUNDS_CHECK_EN
    logic in_range;
    logic err_reg;
    assign in_range = (addr_ext < 32'(DEPTH));
    assign wr_en    = enter_ack && cur_we && in_range && !Rst;
    assign MemErr   = err_reg;
`else
    assign wr_en    = enter_ack && cur_we && !Rst;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && MemReq) begin
                we_reg    <= MemWe;
                addr_reg  <= MemAddr;
                wdata_reg <= MemWData;
                cnt_reg   <= CNT_W'(WAIT_CYCLES);
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
`ifdef DMEM_BOUNDS_CHECK_EN
            err_reg <= enter_ack && !in_range;
            if (enter_ack) begin
                if (!in_range)
                    rdata_reg <= '0;
                else if (!cur_we)
                    rdata_reg <= mem[idx];
            end
`else
            if (enter_ack && !cur_we)
                rdata_reg <= mem[idx];
`endif
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[idx] <= cur_wdata;
    end

    assign MemAck   = (state_reg == ACK);
    assign Busy     = (state_reg != IDLE);
    assign MemRData = rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed test of data_mem_responder: one instance with two wait states and
// an 11-bit address, one with zero wait states.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_we, a_ack, a_busy;
    logic [10:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_ack, b_busy;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        a_err, b_err;
`endif

    data_mem_responder #(.DATA_W(32), .ADDR_W(11), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
        .Clk(clk), .Rst(rst), .MemReq(a_req), .MemWe(a_we), .MemAddr(a_addr),
        .MemWData(a_wdata), .MemAck(a_ack), .MemRData(a_rdata), .Busy(a_busy)
`ifdef DMEM_BOUNDS_CHECK_EN
        , .MemErr(a_err)
`endif
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut_b (
        .Clk(clk), .Rst(rst), .MemReq(b_req), .MemWe(b_we), .MemAddr(b_addr),
        .MemWData(b_wdata), .MemAck(b_ack), .MemRData(b_rdata), .Busy(b_busy)
`ifdef DMEM_BOUNDS_CHECK_EN
        , .MemErr(b_err)
`endif
    );

    int vec_count  = 0;
    int miss_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? b_ack : a_ack;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? b_rdata : a_rdata;
    endfunction

    function automatic logic get_err(input bit sel);
`ifdef DMEM_BOUNDS_CHECK_EN
        return sel ? b_err : a_err;
`else
        return sel ? 1'b0 : 1'b0;
`endif
    endfunction

    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [10:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_req = req; b_we = we; b_addr = addr[9:0]; b_wdata = wdata;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // One complete transaction; lat is the tick count at which MemAck is seen
    // (0 means it never came within the budget).
    task automatic xact(input bit sel, input logic we, input logic [10:0] addr,
                        input logic [31:0] wdata, output int lat, output int busy_n,
                        output logic [31:0] rd, output logic err);
        lat = 0; busy_n = 0; rd = '0; err = 1'b0;
        drive(sel, 1'b1, we, addr, wdata);
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (get_busy(sel)) busy_n++;
            if (get_ack(sel)) begin
                lat = n;
                rd  = get_rdata(sel);
                err = get_err(sel);
            end
        end
        drive(sel, 1'b0, 1'b0, 11'd0, 32'd0);
        tick();
    endtask

    int          lat, busy_n, acks, first, second;
    logic [31:0] rd;
    logic        err;

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        #1 rst = 1'b1;
        #3;
        check("reset_ack",   32'(a_ack),   32'd0);
        check("reset_rdata", a_rdata,      32'd0);
        check("reset_busy",  32'(a_busy),  32'd0);
        #6 rst = 1'b0;
        tick(); tick(); tick();
        check("idle_after_reset_ack",  32'(a_ack | b_ack),   32'd0);
        check("idle_after_reset_busy", 32'(a_busy | b_busy), 32'd0);

        // Store then load with two wait states
        xact(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, lat, busy_n, rd, err);
        check("store5_latency", 32'(lat), 32'd3);
        check("store5_busy",    32'(busy_n), 32'd3);
        check("store5_ack_one_cycle", 32'(a_ack), 32'd0);
        check("store5_idle_after",    32'(a_busy), 32'd0);
        xact(1'b0, 1'b0, 11'd5, 32'd0, lat, busy_n, rd, err);
        check("load5_latency", 32'(lat), 32'd3);
        check("load5_data",    rd, 32'hDEADBEEF);
        tick(); tick();
        check("load5_held", a_rdata, 32'hDEADBEEF);

        // Zero wait states
        xact(1'b1, 1'b1, 11'd9, 32'h12345678, lat, busy_n, rd, err);
        check("w0_store_latency", 32'(lat), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 11'd9, 32'd0);
        acks = 0; first = 0; second = 0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (b_ack) begin
                acks++;
                if (acks == 1) first = n; else second = n;
                check("w0_load_data", b_rdata, 32'h12345678);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        tick();
        check("w0_ack_count", 32'(acks),   32'd2);
        check("w0_first_ack", 32'(first),  32'd1);
        check("w0_second_ack", 32'(second), 32'd3);

        // Held request across 8 cycles
        drive(1'b0, 1'b1, 1'b0, 11'd5, 32'd0);
        acks = 0; first = 0; second = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (a_ack) begin
                acks++;
                if (acks == 1) first = n; else second = n;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        tick();
        check("held_ack_count", 32'(acks), 32'd2);
        check("held_ack_gap",   32'(second - first), 32'd4);

        // Request dropped during WAIT still acks
        drive(1'b0, 1'b1, 1'b0, 11'd5, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        acks = 0; rd = '0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (a_ack) begin
                acks++;
                rd = a_rdata;
            end
        end
        check("drop_ack_count", 32'(acks), 32'd1);
        check("drop_ack_data",  rd, 32'hDEADBEEF);

        // Reset in the middle of a store
        xact(1'b0, 1'b1, 11'd7, 32'h11111111, lat, busy_n, rd, err);
        check("store7_latency", 32'(lat), 32'd3);
        drive(1'b0, 1'b1, 1'b1, 11'd7, 32'h22222222);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_ack",   32'(a_ack),  32'd0);
        check("midrst_busy",  32'(a_busy), 32'd0);
        check("midrst_rdata", a_rdata,     32'd0);
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        tick();
        rst = 1'b0;
        acks = 0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (a_ack) acks++;
        end
        check("midrst_no_ack", 32'(acks), 32'd0);
        xact(1'b0, 1'b0, 11'd7, 32'd0, lat, busy_n, rd, err);
        check("midrst_load7", rd, 32'h11111111);

        // Out-of-range address
        xact(1'b0, 1'b1, 11'd3, 32'h33333333, lat, busy_n, rd, err);
        check("store3_latency", 32'(lat), 32'd3);
        xact(1'b0, 1'b1, 11'd1027, 32'hA5A5A5A5, lat, busy_n, rd, err);
        check("oob_store_latency", 32'(lat), 32'd3);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("oob_err",   32'(err), 32'd1);
        check("oob_rdata", rd,       32'd0);
        xact(1'b0, 1'b0, 11'd3, 32'd0, lat, busy_n, rd, err);
        check("oob_load3", rd, 32'h33333333);
        check("inrange_err", 32'(err), 32'd0);
`else
        xact(1'b0, 1'b0, 11'd3, 32'd0, lat, busy_n, rd, err);
        check("wrap_load3", rd, 32'hA5A5A5A5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
